// File: rtl/ntwrk_size_tally.sv
// Scans the point->network LUT, resolves IDs to remap roots, tallies per root and ranks the NUM_NTWRKS largest sizes.
// No backpressure: one LUT read per cycle; NTWRK_TALLY_PRODUCT_EN adds ntwrk_prod and a MUL pass before DONE.
module ntwrk_size_tally #(
  parameter int NUM_POINTS = 1000,
  parameter int NUM_CONNS  = 1000,
  parameter int NUM_NTWRKS = 3,
  localparam int PW  = $clog2(NUM_POINTS),
  localparam int CW  = $clog2(NUM_CONNS),
  localparam int SW  = $clog2(NUM_POINTS + 1),
  localparam int HW  = $clog2(NUM_CONNS + 1),
  localparam int PRW = NUM_NTWRKS * SW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         pt_rd_en,
  output logic [PW-1:0]                pt_rd_addr,
  input  logic [CW-1:0]                pt_rd_data,
  output logic                         rm_rd_en,
  output logic [CW-1:0]                rm_rd_addr,
  input  logic [CW-1:0]                rm_rd_data,
  output logic [NUM_NTWRKS-1:0][SW-1:0] ntwrk_sz,
  output logic                         ntwrk_sz_vld,
`ifdef NTWRK_TALLY_PRODUCT_EN
  output logic [PRW-1:0]               ntwrk_prod,
`endif
  output logic                         chain_err
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, SCAN_RD, SCAN_WAIT, CHASE, RMW_RD, RMW_WR, NEXT, RANK,
`ifdef NTWRK_TALLY_PRODUCT_EN
    MUL,
`endif
    DONE
  } state_t;

  localparam logic [PW-1:0] LAST_PT  = PW'(NUM_POINTS - 1);
  localparam logic [CW-1:0] LAST_ID  = CW'(NUM_CONNS - 1);
  localparam logic [HW-1:0] LAST_HOP = HW'(NUM_CONNS - 1);
  localparam logic [SW-1:0] SAT_CNT  = SW'(NUM_POINTS);

  state_t        state;
  logic [PW-1:0] p;
  logic [CW-1:0] cur;
  logic [CW-1:0] root;
  logic [HW-1:0] hops;
  logic [CW-1:0] clr_addr;
  logic [CW-1:0] rank_id;
  logic          issued_all;
  logic          rank_vld_q;

  logic [SW-1:0] cnt_ram [NUM_CONNS];
  logic [SW-1:0] ram_q;
  logic          ram_we;
  logic [CW-1:0] ram_waddr;
  logic [CW-1:0] ram_raddr;
  logic [SW-1:0] ram_wdata;
  logic [SW-1:0] rmw_val;

  logic                          offer_vld;
  logic [SW-1:0]                 offer_val;
  logic [NUM_NTWRKS-1:0][SW-1:0] sz_ins;
  logic                          chase_ovf;
  logic                          fin;

`ifdef NTWRK_TALLY_PRODUCT_EN
  localparam int MIW = (NUM_NTWRKS > 1) ? $clog2(NUM_NTWRKS) : 1;
  localparam logic [MIW-1:0] LAST_MUL = MIW'(NUM_NTWRKS - 1);
  logic [MIW-1:0] mul_idx;
  logic [SW-1:0]  mul_fac;
  assign mul_fac = (ntwrk_sz[mul_idx] == '0) ? SW'(1) : ntwrk_sz[mul_idx];
`endif

  assign pt_rd_addr = p;

  // Remap reads follow the returned data combinationally so the walk advances one hop per cycle.
  always_comb begin
    rm_rd_en   = 1'b0;
    rm_rd_addr = pt_rd_data;
    if (state == SCAN_WAIT) begin
      rm_rd_en = (pt_rd_data != '0);
    end else if (state == CHASE) begin
      rm_rd_addr = rm_rd_data;
      rm_rd_en   = (rm_rd_data != '0) && (hops != LAST_HOP);
    end
  end

  assign rmw_val   = (ram_q >= SAT_CNT) ? ram_q : ram_q + SW'(1);
  assign ram_we    = (state == CLEAR) || (state == RMW_WR);
  assign ram_waddr = (state == CLEAR) ? clr_addr : root;
  assign ram_wdata = (state == CLEAR) ? '0 : rmw_val;
  assign ram_raddr = (state == RANK) ? rank_id : root;

  always_ff @(posedge clk) begin
    if (ram_we) cnt_ram[ram_waddr] <= ram_wdata;
    ram_q <= cnt_ram[ram_raddr];
  end

  assign offer_vld = ((state == SCAN_WAIT) && (pt_rd_data == '0)) ||
                     ((state == RANK) && rank_vld_q && (ram_q != '0));
  assign offer_val = (state == RANK) ? ram_q : SW'(1);

  // Strict compare places a new value after existing equal entries, preserving arrival order.
  always_comb begin
    sz_ins = ntwrk_sz;
    if (ntwrk_sz[0] < offer_val) sz_ins[0] = offer_val;
    for (int i = 1; i < NUM_NTWRKS; i++) begin
      if (ntwrk_sz[i] < offer_val) begin
        if (ntwrk_sz[i-1] < offer_val) sz_ins[i] = ntwrk_sz[i-1];
        else                           sz_ins[i] = offer_val;
      end
    end
  end

  assign chase_ovf = (state == CHASE) && (rm_rd_data != '0) && (hops == LAST_HOP);
  assign fin       = chase_ovf || ((state == RANK) && issued_all && rank_vld_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      ntwrk_sz_vld <= 1'b0;
      chain_err    <= 1'b0;
      ntwrk_sz     <= '0;
      pt_rd_en     <= 1'b0;
      p            <= '0;
      cur          <= '0;
      root         <= '0;
      hops         <= '0;
      clr_addr     <= '0;
      rank_id      <= '0;
      issued_all   <= 1'b0;
      rank_vld_q   <= 1'b0;
`ifdef NTWRK_TALLY_PRODUCT_EN
      ntwrk_prod   <= '0;
      mul_idx      <= '0;
`endif
    end else begin
      pt_rd_en   <= 1'b0;
      rank_vld_q <= (state == RANK) && !issued_all;
      if (offer_vld) ntwrk_sz <= sz_ins;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            busy         <= 1'b1;
            ntwrk_sz_vld <= 1'b0;
            chain_err    <= 1'b0;
            ntwrk_sz     <= '0;
            clr_addr     <= '0;
`ifdef NTWRK_TALLY_PRODUCT_EN
            ntwrk_prod   <= '0;
`endif
            state        <= CLEAR;
          end
        end
        CLEAR: begin
          if (clr_addr == LAST_ID) begin
            p        <= '0;
            pt_rd_en <= 1'b1;
            state    <= SCAN_RD;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        SCAN_RD: state <= SCAN_WAIT;
        SCAN_WAIT: begin
          if (pt_rd_data == '0) begin
            state <= NEXT;
          end else begin
            cur   <= pt_rd_data;
            hops  <= '0;
            state <= CHASE;
          end
        end
        CHASE: begin
          if (rm_rd_data == '0) begin
            root  <= cur;
            state <= RMW_RD;
          end else if (hops == LAST_HOP) begin
            chain_err <= 1'b1;
          end else begin
            cur  <= rm_rd_data;
            hops <= hops + 1'b1;
          end
        end
        RMW_RD: state <= RMW_WR;
        // The count write and the point advance share one cycle.
        RMW_WR, NEXT: begin
          if (p == LAST_PT) begin
            rank_id    <= CW'(1);
            issued_all <= 1'b0;
            state      <= RANK;
          end else begin
            p        <= p + 1'b1;
            pt_rd_en <= 1'b1;
            state    <= SCAN_RD;
          end
        end
        RANK: begin
          if (!issued_all) begin
            if (rank_id == LAST_ID) issued_all <= 1'b1;
            else                    rank_id    <= rank_id + 1'b1;
          end
        end
`ifdef NTWRK_TALLY_PRODUCT_EN
        MUL: begin
          ntwrk_prod <= PRW'(ntwrk_prod * PRW'(mul_fac));
          if (mul_idx == LAST_MUL) begin
            busy         <= 1'b0;
            ntwrk_sz_vld <= 1'b1;
            state        <= DONE;
          end else begin
            mul_idx <= mul_idx + 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase

      if (fin) begin
`ifdef NTWRK_TALLY_PRODUCT_EN
        ntwrk_prod <= PRW'(1);
        mul_idx    <= '0;
        state      <= MUL;
`else
        busy         <= 1'b0;
        ntwrk_sz_vld <= 1'b1;
        state        <= DONE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ntwrk_size_tally.sv
// Directed bench for ntwrk_size_tally with a result scoreboard popped on each rising ntwrk_sz_vld.
module tb_ntwrk_size_tally;
  localparam int NP = 8;
  localparam int NC = 8;
  localparam int NN = 3;
  localparam int SW = 4;
  localparam int PW = 3;
  localparam int CW = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  busy;
  logic                  pt_rd_en;
  logic [PW-1:0]         pt_rd_addr;
  logic [CW-1:0]         pt_rd_data = '0;
  logic                  rm_rd_en;
  logic [CW-1:0]         rm_rd_addr;
  logic [CW-1:0]         rm_rd_data = '0;
  logic [NN-1:0][SW-1:0] ntwrk_sz;
  logic                  ntwrk_sz_vld;
  logic                  chain_err;
`ifdef NTWRK_TALLY_PRODUCT_EN
  logic [NN*SW-1:0]      ntwrk_prod;
`endif

  always #5 clk = ~clk;

  ntwrk_size_tally #(.NUM_POINTS(NP), .NUM_CONNS(NC), .NUM_NTWRKS(NN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .pt_rd_en(pt_rd_en), .pt_rd_addr(pt_rd_addr), .pt_rd_data(pt_rd_data),
    .rm_rd_en(rm_rd_en), .rm_rd_addr(rm_rd_addr), .rm_rd_data(rm_rd_data),
    .ntwrk_sz(ntwrk_sz), .ntwrk_sz_vld(ntwrk_sz_vld),
`ifdef NTWRK_TALLY_PRODUCT_EN
    .ntwrk_prod(ntwrk_prod),
`endif
    .chain_err(chain_err)
  );

  // LUT models with one cycle of read latency.
  logic [CW-1:0] pt_lut [NP];
  logic [CW-1:0] rm_lut [NC];
  always @(posedge clk) begin
    if (pt_rd_en) pt_rd_data <= pt_lut[pt_rd_addr];
    if (rm_rd_en) rm_rd_data <= rm_lut[rm_rd_addr];
  end

  typedef struct {
    int s0;
    int s1;
    int s2;
    int err;
    int prod;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic vld_d  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int s0, input int s1, input int s2, input int err, input int prod);
    exp_t e;
    e.s0 = s0; e.s1 = s1; e.s2 = s2; e.err = err; e.prod = prod;
    sb.push_back(e);
  endtask

  // Monitor: enable exclusivity every cycle, result compare on each new ntwrk_sz_vld.
  always @(negedge clk) begin
    chk("rd_en_exclusive", int'(pt_rd_en & rm_rd_en), 0);
    if (ntwrk_sz_vld && !vld_d) begin
      if (sb.size() == 0) begin
        chk("result_expected", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        chk("ntwrk_sz0", int'(ntwrk_sz[0]), mon_e.s0);
        chk("ntwrk_sz1", int'(ntwrk_sz[1]), mon_e.s1);
        chk("ntwrk_sz2", int'(ntwrk_sz[2]), mon_e.s2);
        chk("chain_err", int'(chain_err), mon_e.err);
        chk("busy_in_done", int'(busy), 0);
`ifdef NTWRK_TALLY_PRODUCT_EN
        chk("ntwrk_prod", int'(ntwrk_prod), mon_e.prod);
`endif
      end
    end
    vld_d = ntwrk_sz_vld;
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (!(ntwrk_sz_vld && !busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done"}, int'(ntwrk_sz_vld && !busy), 1);
  endtask

  task automatic wait_pt_en;
    int t = 0;
    while (!pt_rd_en && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("saw_pt_rd_en", int'(pt_rd_en), 1);
  endtask

  task automatic wait_rm_en;
    int t = 0;
    while (!rm_rd_en && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("saw_rm_rd_en", int'(rm_rd_en), 1);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_vld"}, int'(ntwrk_sz_vld), 0);
    chk({nm, "_err"}, int'(chain_err), 0);
    chk({nm, "_sz"}, int'(ntwrk_sz), 0);
    chk({nm, "_pt_en"}, int'(pt_rd_en), 0);
    chk({nm, "_rm_en"}, int'(rm_rd_en), 0);
    chk({nm, "_pt_addr"}, int'(pt_rd_addr), 0);
`ifdef NTWRK_TALLY_PRODUCT_EN
    chk({nm, "_prod"}, int'(ntwrk_prod), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    pt_lut = '{0, 0, 0, 0, 0, 0, 0, 0};
    rm_lut = '{0, 0, 0, 0, 0, 0, 0, 0};
    clk_n(3);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    clk_n(1);

    // All singletons.
    push(1, 1, 1, 0, 1);
    pulse_start();
    wait_done("t1");

    // Flat networks of 4, 2, 1 plus one singleton.
    pt_lut = '{1, 1, 1, 1, 2, 2, 3, 0};
    push(4, 2, 1, 0, 8);
    pulse_start();
    wait_done("t2");

    // IDs 1 and 2 remap into root 3.
    rm_lut = '{0, 3, 3, 0, 0, 0, 0, 0};
    pt_lut = '{1, 1, 2, 2, 3, 0, 0, 0};
    push(5, 1, 1, 0, 5);
    pulse_start();
    wait_done("t3");

    // Remap cycle 1->2->1 trips the hop limit at point 0.
    rm_lut = '{0, 2, 1, 0, 0, 0, 0, 0};
    pt_lut = '{1, 0, 0, 0, 0, 0, 0, 0};
    push(0, 0, 0, 1, 1);
    pulse_start();
    wait_done("t4");

    // Start while scanning is ignored.
    rm_lut = '{0, 0, 0, 0, 0, 0, 0, 0};
    pt_lut = '{1, 1, 1, 1, 2, 2, 3, 0};
    push(4, 2, 1, 0, 8);
    pulse_start();
    wait_pt_en();
    clk_n(2);
    chk("busy_mid_scan", int'(busy), 1);
    pulse_start();
    chk("busy_after_ignored_start", int'(busy), 1);
    wait_done("t5a");
    clk_n(3);
    chk("no_restart_busy", int'(busy), 0);

    // Reset during the remap walk.
    rm_lut = '{0, 3, 3, 0, 0, 0, 0, 0};
    pt_lut = '{1, 1, 2, 2, 3, 0, 0, 0};
    pulse_start();
    wait_rm_en();
    @(negedge clk);
    chk("busy_in_chase", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid_reset");
    rst_n = 1'b1;
    clk_n(1);
    push(5, 1, 1, 0, 5);
    pulse_start();
    wait_done("t5b");

    // Back-to-back run from DONE with a new LUT.
    rm_lut = '{0, 0, 0, 0, 0, 0, 0, 0};
    pt_lut = '{1, 1, 1, 1, 2, 2, 3, 0};
    push(4, 2, 1, 0, 8);
    pulse_start();
    chk("vld_drop_after_start", int'(ntwrk_sz_vld), 0);
    chk("busy_after_start", int'(busy), 1);
    wait_done("t6");

    clk_n(5);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntwrk_size_tally.md
Name: ntwrk_size_tally

Overview:
Read-side companion to the point/network builder. After all connections are written, this block scans the point->network LUT one point at a time. It resolves each network ID through the remap linked list to its root, tallies points per root in an internal count RAM, and ranks the NUM_NTWRKS largest circuit sizes. Singleton points (network ID 0) count as circuits of size 1.

Parameters:
NUM_POINTS, 1000, number of points; point LUT depth
NUM_CONNS, 1000, network ID space; remap LUT and count RAM depth
NUM_NTWRKS, 3, number of largest sizes reported

Ports:
clk  in  1  clock
rst_n  in  1  reset: synchronous, active-low
start  in  1  single-cycle pulse; begins a tally
busy  out  1  high from the cycle after an accepted start until DONE
pt_rd_en  out  1  point LUT read enable
pt_rd_addr  out  $clog2(NUM_POINTS)  point index
pt_rd_data  in  $clog2(NUM_CONNS)  network ID; valid 1 cycle after pt_rd_en
rm_rd_en  out  1  remap LUT read enable
rm_rd_addr  out  $clog2(NUM_CONNS)  network ID
rm_rd_data  in  $clog2(NUM_CONNS)  next ID (0 = root); valid 1 cycle after rm_rd_en
ntwrk_sz  out  [NUM_NTWRKS] x $clog2(NUM_POINTS+1)  sizes; index 0 is the largest
ntwrk_sz_vld  out  1  held high in DONE
chain_err  out  1  remap walk exceeded NUM_CONNS hops

Behaviour:
- Reset: state IDLE; busy=0, ntwrk_sz_vld=0, chain_err=0, all ntwrk_sz=0, read enables=0, point/hop counters=0.
- start accepted only in IDLE or DONE. An accepted start clears ntwrk_sz, ntwrk_sz_vld and chain_err, then enters CLEAR. start while busy is ignored.
- CLEAR: zero count RAM addresses 0..NUM_CONNS-1, one per cycle (NUM_CONNS cycles), then go to SCAN_RD with point index p=0.
- SCAN_RD: assert pt_rd_en with addr p for 1 cycle, then SCAN_WAIT.
- SCAN_WAIT: sample pt_rd_data.
  - ID 0: offer size 1 to the ranker; go to NEXT.
  - ID nonzero: set cur=ID, hops=0; issue rm_rd addr cur; go to CHASE.
- CHASE, per cycle with rm_rd_data valid:
  - rm_rd_data==0: root=cur; go to RMW_RD.
  - Otherwise: cur=rm_rd_data, hops+1, reissue rm_rd addr cur.
  - If hops reaches NUM_CONNS: chain_err=1 (sticky for the run); go to DONE immediately; ntwrk_sz shows the ranker contents at that point.
- RMW_RD: read count[root] (1 cycle). RMW_WR: write count+1 (saturates at NUM_POINTS), then NEXT.
- NEXT: if p==NUM_POINTS-1, go to RANK with id=1; else p+1, then SCAN_RD. Per-point cost: 3 cycles for a singleton; 5+H cycles for a non-singleton, where H is the number of nonzero remap hops.
- RANK: read count[id] for id=1..NUM_CONNS-1 with 1-cycle read latency, one ID per cycle, pipelined. Offer each nonzero count to the ranker. Go to DONE one cycle after the last data. Non-root IDs hold count 0 and contribute nothing.
- Ranker: an NUM_NTWRKS-entry register list in descending order, one offer per cycle.
  - The offered value is inserted before the first entry strictly smaller than it; lower entries shift down and the last entry drops.
  - Equal values keep arrival order.
  - Unfilled slots stay 0.
  - ntwrk_sz mirrors the list continuously; values are only meaningful when ntwrk_sz_vld is high.
- DONE: busy=0, ntwrk_sz_vld=1. Stays here until start or reset.
- Reset mid-operation: next cycle returns to IDLE and all reset values apply. Count RAM contents are don't-care, since CLEAR rewrites them.
- Never writes either LUT. Only one of pt_rd_en / rm_rd_en is high in any cycle.

Optional Feature:
Macro NTWRK_TALLY_PRODUCT_EN.
- Defined:
  - Adds output ntwrk_prod, width NUM_NTWRKS*$clog2(NUM_POINTS+1), and a MUL state between RANK (and the chain_err exit) and DONE.
  - MUL uses NUM_NTWRKS cycles with one multiply per cycle: product=1, then product *= ntwrk_sz[i].
  - Slots holding 0 are treated as 1.
  - ntwrk_prod is reset to 0 and is valid with ntwrk_sz_vld.
- Undefined: no port, no MUL state; RANK goes straight to DONE.

Test Plan:
1. NUM_POINTS=8, NUM_CONNS=8. All point IDs 0 -> ntwrk_sz={1,1,1}, ntwrk_sz_vld=1, chain_err=0.
2. Points 0-3 ID1, points 4-5 ID2, point 6 ID3, point 7 ID0, remap all 0 -> {4,2,1}. With macro: ntwrk_prod=8.
3. rm[1]=3, rm[2]=3; points 0-1 ID1, points 2-3 ID2, point 4 ID3, rest 0 -> {5,1,1}.
4. rm[1]=2, rm[2]=1, point 0 ID1 -> chain_err=1, ntwrk_sz_vld=1 after 8 hops, busy=0.
5. start pulsed during SCAN -> ignored; the first run's result is unchanged. rst_n low during CHASE -> next cycle busy=0, ntwrk_sz_vld=0, sizes 0. A rerun then gives the correct result.
6. Back-to-back runs: second start in DONE with a changed LUT -> ntwrk_sz_vld drops the cycle after start; new sizes reflect only the new LUT, with no stale counts.
